// File: rtl/cont_ctrl.sv
// Programmable interval timer controller: prescaled enable, terminal-count flag, optional auto-reload.
// Latency: launch on the start-sampling edge; done pulses (period_q+1)*(prescale_q+1) edges later.
// Backpressure: none; pause freezes the count and prescaler, and stop aborts to IDLE with top priority.
// Optional feature: define CONT_CTRL_IRQ_EN to add a sticky irq flag with an irq_clr input.
module cont_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef CONT_CTRL_IRQ_EN
    input  logic                  irq_clr,
    output logic                  irq,
`endif
    output logic [WIDTH-1:0]      cnt,
    output logic                  en,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    logic [WIDTH-1:0]      period_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  reload_q;
    logic [PRESCALE_W-1:0] presc;

    logic [1:0]            state_nxt;
    logic [WIDTH-1:0]      cnt_nxt;
    logic [PRESCALE_W-1:0] presc_nxt;
    logic                  en_nxt;
    logic                  done_nxt;
    logic                  latch;

    // Next-state, prescaler and counter decisions; stop overrides everything else.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        presc_nxt = presc;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        latch     = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            presc_nxt = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        latch     = 1'b1;
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        presc_nxt = '0;
                    end
                end
                default: begin
                    // RUN and HOLD share one path: pause freezes, otherwise the
                    // prescaler steps, so leaving HOLD resumes counting on that same edge.
                    if (pause) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                        if (presc == prescale_q) begin
                            en_nxt    = 1'b1;
                            presc_nxt = '0;
                            if (cnt == period_q) begin
                                done_nxt = 1'b1;
                                if (reload_q) begin
                                    cnt_nxt = '0;
                                end else begin
                                    state_nxt = DONE;
                                end
                            end else begin
                                cnt_nxt = cnt + 1'b1;
                            end
                        end else begin
                            presc_nxt = presc + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Registered state, outputs and launch-time configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            presc      <= '0;
            en         <= 1'b0;
            done       <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
            reload_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            presc <= presc_nxt;
            en    <= en_nxt;
            done  <= done_nxt;
            if (latch) begin
                period_q   <= period;
                prescale_q <= prescale;
                reload_q   <= auto_reload;
            end
        end
    end

    assign busy = (state == RUN) || (state == HOLD);

`ifdef CONT_CTRL_IRQ_EN
    // Sticky completion flag; a done pulse outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cont_ctrl.sv
// Bench for cont_ctrl: expected done pulses are queued at launch and matched by a monitor.
module tb_cont_ctrl;
    localparam int WIDTH = 4;
    localparam int PW    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, pause, auto_reload;
    logic [WIDTH-1:0] period;
    logic [PW-1:0]    prescale;
    logic [WIDTH-1:0] cnt;
    logic             en, busy, done;
    logic [1:0]       state;
`ifdef CONT_CTRL_IRQ_EN
    logic             irq_clr;
    logic             irq;
`endif

    cont_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .period(period), .prescale(prescale),
`ifdef CONT_CTRL_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .cnt(cnt), .en(en), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        int st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int n, input int s);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        e.st  = s;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle start; returns at the negedge after the launch edge.
    task automatic launch(input int p, input int ps, input logic ar);
        period      = WIDTH'(p);
        prescale    = PW'(ps);
        auto_reload = ar;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_cnt", cnt, mon_e.cnt);
                chk("done_state", state, mon_e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        auto_reload = 1'b0; period = '0; prescale = '0;
`ifdef CONT_CTRL_IRQ_EN
        irq_clr = 1'b0;
`endif
        wait_n(2);
        reset = 1'b1;
        wait_n(1);
        chk("rst_cnt", cnt, 0);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", en, 0);
`ifdef CONT_CTRL_IRQ_EN
        chk("rst_irq", irq, 0);
`endif

        // One-shot period 5, prescale 0; period changed after launch must not matter.
        push_exp(cyc + 7, 5, 3);
        launch(5, 0, 1'b0);
        period = 4'd2;
        chk("os_state_run", state, 1);
        chk("os_cnt0", cnt, 0);
        chk("os_busy", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            wait_n(1);
            chk("os_cnt_step", cnt, k);
        end
        wait_n(2);
        chk("os_state_done", state, 3);
        chk("os_cnt_hold", cnt, 5);
        chk("os_busy_done", busy, 0);
        chk("os_done_once", done, 0);

        // Asynchronous reset in the middle of a run.
        launch(7, 0, 1'b0);
        wait_n(3);
        chk("ar_pre_cnt", cnt, 3);
        #2 reset = 1'b0;
        #1;
        chk("ar_cnt", cnt, 0);
        chk("ar_state", state, 0);
        chk("ar_busy", busy, 0);
        chk("ar_en", en, 0);
        chk("ar_done", done, 0);
        wait_n(1);
        reset = 1'b1;
        wait_n(2);
        chk("ar_no_resume", state, 0);
        chk("ar_no_resume_cnt", cnt, 0);

        // Auto-reload period 3, prescale 2; prescale changed mid-run is ignored.
        c0 = cyc;
        for (int k = 1; k <= 3; k++) push_exp(c0 + 1 + 12 * k, 0, 1);
        launch(3, 2, 1'b1);
        for (int j = 1; j <= 36; j++) begin
            if (j == 5) prescale = 8'd0;
            wait_n(1);
            chk("rl_en", en, (j % 3 == 0) ? 1 : 0);
            chk("rl_cnt", cnt, (j / 3) % 4);
            chk("rl_state", state, 1);
        end
        stop = 1'b1;
        wait_n(1);
        stop = 1'b0;
        chk("rl_stop_state", state, 0);
        chk("rl_stop_cnt", cnt, 0);
        chk("rl_stop_en", en, 0);

        // period 0: done after prescale+1 cycles.
        push_exp(cyc + 5, 0, 3);
        launch(0, 3, 1'b0);
        wait_n(4);
        chk("p0_state", state, 3);
        chk("p0_cnt", cnt, 0);

        // stop on the terminal tick suppresses done.
        launch(0, 0, 1'b0);
        stop = 1'b1;
        wait_n(1);
        stop = 1'b0;
        chk("st_term_state", state, 0);
        chk("st_term_done", done, 0);

        // Pause for 4 cycles at cnt 2 delays done by 4 cycles.
        push_exp(cyc + 13, 7, 3);
        launch(7, 0, 1'b0);
        wait_n(2);
        chk("pa_pre_cnt", cnt, 2);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_n(1);
            chk("pa_state", state, 2);
            chk("pa_cnt", cnt, 2);
            chk("pa_en", en, 0);
            chk("pa_busy", busy, 1);
        end
        pause = 1'b0;
        wait_n(1);
        chk("pa_resume_state", state, 1);
        chk("pa_resume_cnt", cnt, 3);
        wait_n(6);
        chk("pa_final_state", state, 3);
        chk("pa_final_cnt", cnt, 7);
        pause = 1'b1;
        wait_n(1);
        pause = 1'b0;
        chk("pa_in_done_ignored", state, 3);

        // start in RUN is ignored; start+stop goes IDLE; relaunch from IDLE.
        launch(7, 0, 1'b0);
        wait_n(4);
        chk("rs_pre_cnt", cnt, 4);
        start  = 1'b1;
        period = 4'd1;
        wait_n(1);
        start = 1'b0;
        chk("rs_ignored_cnt", cnt, 5);
        chk("rs_ignored_state", state, 1);
        start = 1'b1;
        stop  = 1'b1;
        wait_n(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("rs_stop_state", state, 0);
        chk("rs_stop_cnt", cnt, 0);
        push_exp(cyc + 3, 1, 3);
        launch(1, 0, 1'b0);
        wait_n(2);
        chk("rs_relaunch_state", state, 3);
        chk("rs_relaunch_cnt", cnt, 1);

`ifdef CONT_CTRL_IRQ_EN
        push_exp(cyc + 4, 2, 3);
        launch(2, 0, 1'b0);
        wait_n(4);
        chk("irq_set", irq, 1);
        chk("irq_state", state, 3);
        wait_n(2);
        chk("irq_hold", irq, 1);
        irq_clr = 1'b1;
        wait_n(1);
        chk("irq_clr", irq, 0);
        push_exp(cyc + 4, 2, 3);
        launch(2, 0, 1'b0);
        wait_n(2);
        chk("irq_pre_done", irq, 0);
        wait_n(2);
        chk("irq_set_beats_clr", irq, 1);
        irq_clr = 1'b0;
        stop    = 1'b1;
        wait_n(1);
        stop = 1'b0;
        chk("irq_survives_stop", irq, 1);
        chk("irq_stop_state", state, 0);
`endif

        wait_n(2);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cont_ctrl.md
Name: cont_ctrl

Overview:
Sequencing controller for the 4-bit enable counter datapath. It turns it into a programmable interval timer with start, stop and pause control. A prescaler generates the count-enable strobe, and an FSM latches period and prescale on start. The block flags terminal count and optionally auto-reloads. It sits between the control/register logic and the counter, and is the only source of the counter's enable.

Parameters:
WIDTH, 4, counter and period width in bits
PRESCALE_W, 8, prescaler and prescale-value width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch a count sequence (sampled level)
stop  input  1  abort to IDLE (sampled level, highest priority)
pause  input  1  level: freeze counting while high in RUN/HOLD
auto_reload  input  1  1 = periodic, 0 = one-shot; latched on start
period  input  WIDTH  terminal count value; latched on start
prescale  input  PRESCALE_W  enable strobe every prescale+1 cycles; latched on start
cnt  output  WIDTH  current count
en  output  1  count-enable strobe (1-cycle pulse per increment tick)
busy  output  1  high in RUN and HOLD
done  output  1  1-cycle pulse at terminal tick
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (reset=0) takes effect immediately and asynchronously: state=IDLE, and cnt, en, busy, done, the prescaler and the latched registers all =0. Reset asserted mid-sequence aborts it; nothing resumes after release.
- All outputs are registered. busy is derived from the registered state.
- IDLE:
  - start=1 latches period_q, prescale_q and reload_q.
  - cnt=0, presc=0, next state RUN.
- RUN:
  - presc counts 0..prescale_q.
  - When presc==prescale_q: en=1 for that cycle, presc<=0, and it is a tick. Otherwise presc++.
  - prescale_q=0 gives a tick every cycle.
- Tick with cnt!=period_q: cnt<=cnt+1.
- Tick with cnt==period_q (terminal):
  - done=1 for exactly one cycle.
  - If reload_q: cnt<=0 and stay in RUN.
  - Else: cnt holds period_q and go to DONE.
- Sequence length:
  - One-shot: done is asserted (period_q+1)*(prescale_q+1) cycles after the start-sampling edge.
  - period_q=0: done after prescale_q+1 cycles.
- pause=1 in RUN goes to HOLD on the next edge, with cnt and presc frozen and en=0. pause=0 in HOLD returns to RUN and the prescaler resumes from its frozen value.
- DONE:
  - busy=0, cnt holds.
  - start=1 relaunches exactly as from IDLE, with new latches.
- stop=1 in any state goes to IDLE with cnt=0, presc=0, en=0 and done=0.
  - stop beats start and pause when asserted in the same cycle.
  - A stop coinciding with a terminal tick suppresses done.
- start while in RUN or HOLD is ignored: no restart, no relatch.
- Changes to period, prescale or auto_reload after launch have no effect until the next start.
- pause sampled in IDLE or DONE is ignored.
- cnt never exceeds period_q. No wrap past 2^WIDTH-1 is possible because period is WIDTH bits.

Optional Feature:
CONT_CTRL_IRQ_EN
- Defined: adds input irq_clr (1 bit) and output irq (1 bit).
  - irq is a sticky flag set on any done pulse and cleared by irq_clr=1.
  - A set in the same cycle as irq_clr wins, so irq stays 1.
  - Reset clears irq to 0. stop does not clear it.
- Not defined: neither port exists, and the done pulse is the only completion indication.

Test Plan:
- reset=0 for 2 cycles, then release → cnt=0, state=00, busy=0, done=0, en=0. Then reassert reset while cnt=3 in RUN → all outputs 0 immediately, without waiting for a clock edge.
- period=5, prescale=0, auto_reload=0, start 1 cycle → cnt steps 1,2,3,4,5 on consecutive edges. done=1 on the 6th edge after start for one cycle, then state=11, cnt stays 5, busy=0.
- period=3, prescale=2, auto_reload=1 → en pulses every 3 cycles and cnt goes 0,1,2,3,0… Checks:
  - done every 12 cycles, state stays 01.
  - stop=1 → state=00, cnt=0 on the next edge.
- period=7, prescale=0, pause high 4 cycles at cnt=2 → state=10, cnt frozen at 2, en=0. After release counting resumes, and done arrives 4 cycles later than the unpaused run (12 cycles after start instead of 8).
- In RUN at cnt=4: start alone → ignored, cnt continues 5. Then start+stop together → state=00, cnt=0. Then start with period=1 from DONE/IDLE → relaunch, done after 2 cycles.
- With CONT_CTRL_IRQ_EN defined:
  - One-shot period=2 → irq=1 after done and holds through DONE.
  - irq_clr=1 → irq=0.
  - irq_clr held during the next done cycle → irq=1.
